// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg: shared types and constants for the sequential divider.
//   div_state_t  : controller states (IDLE, CALC, FIXUP, DONE)
//   DIV_WIDTH    : default operand width
//   DIV_LATENCY  : cycles from the accepting edge of start to the done cycle,
//                  counting the accepting edge itself. It depends on the
//                  optional signed build (macro SIGNED_DIV_EN), which adds
//                  one FIXUP cycle.
// -----------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

  localparam int DIV_WIDTH = 32;

`ifdef SIGNED_DIV_EN
  localparam int DIV_LATENCY = DIV_WIDTH + 2;
`else
  localparam int DIV_LATENCY = DIV_WIDTH + 1;
`endif

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step: one combinational restoring shift-subtract step.
// Ports:
//   rem         in   WIDTH  current partial remainder
//   quo         in   WIDTH  dividend bits still to consume (MSB first), with
//                           quotient bits accumulating from the LSB end
//   divisor_mag in   WIDTH  divisor magnitude
//   rem_next    out  WIDTH  partial remainder after this step
//   quo_next    out  WIDTH  quo shifted left with the new quotient bit
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // The partial remainder is always below the divisor, so before the final
  // step its top bit is zero; keeping it in the shifted value anyway gives a
  // borrow test that stays correct without relying on that property.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             borrow;

  assign shifted  = {rem, quo[WIDTH-1]};
  assign trial    = {1'b0, shifted} - {2'b00, divisor_mag};
  assign borrow   = trial[WIDTH+1];

  // No borrow: the divisor fits, keep the difference and shift in a 1.
  assign rem_next = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/divider_seq.sv
// -----------------------------------------------------------------------------
// divider_seq: multi-cycle integer divider, one quotient bit per cycle using
// restoring shift-subtract. Result is packed {remainder, quotient} so a HiLo
// register loads Hi = remainder, Lo = quotient.
//
// Optional build macro SIGNED_DIV_EN: honours is_signed (operands converted to
// magnitudes on capture, signs applied in an extra FIXUP cycle). Without it
// the divider is unsigned only and the last CALC edge writes the result.
//
// Ports:
//   clk          in   1        rising-edge clock
//   reset        in   1        synchronous active-high; abandons any operation
//   start        in   1        request, sampled only in IDLE or DONE
//   dividend     in   WIDTH    numerator, captured on accepted start
//   divisor      in   WIDTH    denominator, captured on accepted start
//   is_signed    in   1        DIV (1) / DIVU (0); used only in signed build
//   busy         out  1        high from the cycle after an accepted start
//                              until done
//   done         out  1        one-cycle pulse, div_ans valid from here on
//   div_ans      out  2*WIDTH  {remainder, quotient}, held until next result
//   div_by_zero  out  1        captured divisor was zero, held with div_ans
// -----------------------------------------------------------------------------
module divider_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               is_signed,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] div_ans,
  output logic               div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t       state_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] divisor_mag_reg;
  logic             dz_reg;

  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;

`ifdef SIGNED_DIV_EN
  logic neg_dividend;
  logic neg_divisor;
  logic neg_quo_reg;
  logic neg_rem_reg;

  assign neg_dividend = is_signed & dividend[WIDTH-1];
  assign neg_divisor  = is_signed & divisor[WIDTH-1];
  // 0x80..0 negates to itself, which is exactly its unsigned magnitude.
  assign dividend_mag = neg_dividend ? -dividend : dividend;
  assign divisor_mag  = neg_divisor  ? -divisor  : divisor;
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign dividend_mag     = dividend;
  assign divisor_mag      = divisor;
`endif

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem         (rem_reg),
    .quo         (quo_reg),
    .divisor_mag (divisor_mag_reg),
    .rem_next    (rem_next),
    .quo_next    (quo_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      count_reg       <= '0;
      rem_reg         <= '0;
      quo_reg         <= '0;
      divisor_mag_reg <= '0;
      dz_reg          <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_quo_reg     <= 1'b0;
      neg_rem_reg     <= 1'b0;
`endif
      busy            <= 1'b0;
      done            <= 1'b0;
      div_ans         <= '0;
      div_by_zero     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            rem_reg         <= '0;
            quo_reg         <= dividend_mag;
            divisor_mag_reg <= divisor_mag;
            dz_reg          <= (divisor == '0);
`ifdef SIGNED_DIV_EN
            neg_quo_reg     <= neg_dividend ^ neg_divisor;
            neg_rem_reg     <= neg_dividend;
`endif
            count_reg       <= CW'(WIDTH - 1);
            busy            <= 1'b1;
            state_reg       <= CALC;
          end else begin
            state_reg <= IDLE;
          end
        end

        CALC: begin
          rem_reg   <= rem_next;
          quo_reg   <= quo_next;
          count_reg <= count_reg - 1'b1;
          if (count_reg == '0) begin
`ifdef SIGNED_DIV_EN
            state_reg   <= FIXUP;
`else
            // Unsigned build: the final step's outputs are the result.
            div_ans     <= {rem_next, quo_next};
            div_by_zero <= dz_reg;
            done        <= 1'b1;
            busy        <= 1'b0;
            state_reg   <= DONE;
`endif
          end
        end

`ifdef SIGNED_DIV_EN
        FIXUP: begin
          // Quotient sign is the xor of operand signs; remainder follows the
          // dividend. This also yields 0x80..0 / -1 = 0x80..0 remainder 0.
          div_ans     <= {(neg_rem_reg ? -rem_reg : rem_reg),
                          (neg_quo_reg ? -quo_reg : quo_reg)};
          div_by_zero <= dz_reg;
          done        <= 1'b1;
          busy        <= 1'b0;
          state_reg   <= DONE;
        end
`endif

        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// -----------------------------------------------------------------------------
// tb_divider_seq: directed self-checking bench for divider_seq. Expected
// results are pushed to a scoreboard when an operation is started and popped
// when done is observed. Works in both the unsigned and the SIGNED_DIV_EN
// build; the reference model ignores is_signed when the macro is undefined.
// -----------------------------------------------------------------------------
module tb_divider_seq;
  import div_pkg::*;

  localparam int W = DIV_WIDTH;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   dividend;
  logic [W-1:0]   divisor;
  logic           is_signed;
  logic           busy;
  logic           done;
  logic [2*W-1:0] div_ans;
  logic           div_by_zero;

  int checks = 0;
  int passed = 0;
  int cyc_cnt = 0;
  int start_edge = 0;

  logic [2*W-1:0] exp_ans_q[$];
  logic           exp_dz_q[$];

  divider_seq #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .busy        (busy),
    .done        (done),
    .div_ans     (div_ans),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
  endtask

  // Reference: divide magnitudes with the language operators, then apply signs.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sg);
    logic [W-1:0] am, bm, q, r;
    logic         na, nb, eff;
`ifdef SIGNED_DIV_EN
    eff = sg;
`else
    eff = 1'b0;
`endif
    na = eff && a[W-1];
    nb = eff && b[W-1];
    am = na ? -a : a;
    bm = nb ? -b : b;
    if (bm == '0) begin
      q = '1;
      r = am;
    end else begin
      q = am / bm;
      r = am % bm;
    end
    if (na ^ nb) q = -q;
    if (na) r = -r;
    return {r, q};
  endfunction

  // Called at #1 after an edge; the next edge accepts the start.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                          input logic [2*W-1:0] exp);
    dividend  = a;
    divisor   = b;
    is_signed = sg;
    start     = 1'b1;
    exp_ans_q.push_back(exp);
    exp_dz_q.push_back(b == '0);
    @(posedge clk);
    #1;
    start      = 1'b0;
    start_edge = cyc_cnt;
    $display("start  %08h / %08h signed=%0d expect %016h", a, b, sg, exp);
    check("busy_after_start", busy, 1);
    check("done_after_start", done, 0);
  endtask

  task automatic wait_done(input string tag);
    logic [2*W-1:0] ea;
    logic           ed;
    while (!done && (cyc_cnt - start_edge) < 200) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_latency"}, cyc_cnt - start_edge + 1, DIV_LATENCY);
    check({tag, "_busy_at_done"}, busy, 0);
    if (exp_ans_q.size() == 0) begin
      checks++;
      $error("FAIL %s_scoreboard: observed done with no expectation, expected none", tag);
    end else begin
      ea = exp_ans_q.pop_front();
      ed = exp_dz_q.pop_front();
      $display("done   %s div_ans=%016h div_by_zero=%0d", tag, div_ans, div_by_zero);
      check({tag, "_div_ans"}, div_ans, ea);
      check({tag, "_div_by_zero"}, div_by_zero, ed);
    end
  endtask

  // No done pulse for n cycles, and the held result must not move.
  task automatic idle_check(input string tag, input int n);
    int             pulses;
    logic [2*W-1:0] held;
    pulses = 0;
    held   = div_ans;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    $display("idle   %s %0d cycles, done pulses=%0d", tag, n, pulses);
    check({tag, "_done_pulses"}, pulses, 0);
    check({tag, "_ans_held"}, div_ans, held);
  endtask

  initial begin
    logic [W-1:0] ra, rb;

    reset     = 1'b1;
    start     = 1'b0;
    dividend  = '0;
    divisor   = '0;
    is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_div_ans", div_ans, 0);
    check("reset_div_by_zero", div_by_zero, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic unsigned cases from the plan.
    start_op(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E);
    wait_done("u100_7");
    idle_check("after_u100_7", 3);
    start_op(32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF);
    wait_done("uffff_1");
    start_op(32'd5, 32'd0, 1'b0, 64'h00000005_FFFFFFFF);
    wait_done("u5_0");

    // Reset 10 cycles into an operation: outputs clear, no done follows.
    dividend = 32'd77;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    $display("reset  mid-operation busy=%0d done=%0d div_ans=%016h", busy, done, div_ans);
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_div_ans", div_ans, 0);
    check("midreset_div_by_zero", div_by_zero, 0);
    idle_check("after_reset", 50);
    start_op(32'd9, 32'd3, 1'b0, 64'h00000000_00000003);
    wait_done("u9_3");

    // A second start during CALC must be ignored.
    start_op(32'd1000, 32'd7, 1'b0, 64'h00000006_0000008E);
    repeat (5) @(posedge clk);
    #1;
    dividend = 32'd55;
    divisor  = 32'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("midcalc_busy", busy, 1);
    wait_done("midcalc");
    idle_check("midcalc_extra", 40);

    // Signed cases (in the unsigned build is_signed must be ignored).
`ifdef SIGNED_DIV_EN
    start_op(-32'sd7, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD);
    wait_done("s_m7_2");
    start_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000);
    wait_done("s_ovf");
`else
    start_op(-32'sd7, 32'd2, 1'b1, 64'h00000001_7FFFFFFC);
    wait_done("s_m7_2_ignored");
    start_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h80000000_00000000);
    wait_done("s_ovf_ignored");
`endif
    start_op(-32'sd5, 32'd0, 1'b1, model(-32'sd5, 32'd0, 1'b1));
    wait_done("s_m5_0");
    start_op(32'd17, -32'sd5, 1'b1, model(32'd17, -32'sd5, 1'b1));
    wait_done("s_17_m5");

    // Back-to-back: start held in the DONE cycle.
    start_op(32'd200, 32'd9, 1'b0, 64'h00000002_00000016);
    wait_done("b2b_first");
    start_op(32'd20, 32'd6, 1'b0, 64'h00000002_00000003);
    wait_done("b2b_second");

    // A few random operands against the reference model.
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = (i == 0) ? W'($urandom_range(1, 255)) : $urandom;
      start_op(ra, rb, 1'b0, model(ra, rb, 1'b0));
      wait_done("rand_u");
      ra = $urandom;
      rb = $urandom_range(1, 1000);
      start_op(ra, rb, 1'b1, model(ra, rb, 1'b1));
      wait_done("rand_s");
    end

    check("scoreboard_drained", exp_ans_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
